// File: rtl/sqrt_pkg.sv
// Shared constants and width helpers for the iterative square-root datapath.
// Every width is derived from the radicand width so that the units always agree.
package sqrt_pkg;

  // The root is built by summing odd numbers: sq = 1, 4, 9, ... and del = 3, 5, 7, ...
  localparam int SQ_INIT  = 1;
  localparam int DEL_INIT = 3;
  localparam int DEL_STEP = 2;

  // sq must be able to hold the overshoot square 2^width.
  function automatic int sq_w(input int width);
    return width + 1;
  endfunction

  // del reaches 2^(width/2+1)+1 on the final step.
  function automatic int del_w(input int width);
    return width / 2 + 2;
  endfunction

  function automatic int root_w(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/sqrt_datapath_if.sv
// Control bus between the sqrt controller FSM (master) and the datapath (slave).
// The controller drives the enables on negedge and samples greater on negedge.
interface sqrt_datapath_if;
  logic en_a;
  logic en_del;
  logic en_sq;
  logic en_out;
  logic ld_add;
  logic greater;

  modport master (
    output en_a, en_del, en_sq, en_out, ld_add,
    input  greater
  );

  modport slave (
    input  en_a, en_del, en_sq, en_out, ld_add,
    output greater
  );
endinterface

// File: rtl/sqrt_ld_add_reg.sv
// Enabled register that either reloads a constant or accumulates an operand.
// Shared by the sq and del registers of the square-root datapath.
module sqrt_ld_add_reg #(
  parameter int W    = 8,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         ld_add,
  input  logic [W-1:0] add_val,
  output logic [W-1:0] q
);

  // NOTE: the clear sits in the sensitivity list, so it acts without waiting
  // for a clock edge; every flop in this datapath follows the same pattern.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      // NOTE: registers take non-blocking assignments so that every flop reads
      // the pre-edge value of its neighbours on the same edge.
      q <= ld_add ? q + add_val : W'(INIT);
    end
  end

endmodule

// File: rtl/sqrt_datapath.sv
// Datapath for the iterative integer square-root finder (sum of odd numbers).
// Optional add-step counter output iter_cnt is enabled by SQRT_DATAPATH_ITER_CNT_EN.
module sqrt_datapath
  import sqrt_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SQ_W   = sq_w(WIDTH),
  parameter int DEL_W  = del_w(WIDTH),
  parameter int ROOT_W = root_w(WIDTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WIDTH-1:0]  din,
  sqrt_datapath_if.slave    ctrl,
  output logic [ROOT_W-1:0] root,
  output logic              root_valid
`ifdef SQRT_DATAPATH_ITER_CNT_EN
  ,
  output logic [ROOT_W:0]   iter_cnt
`endif
);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("sqrt_datapath: WIDTH must be even and >= 2");
  end

  logic [WIDTH-1:0]  a_reg;
  logic [SQ_W-1:0]   sq;
  logic [DEL_W-1:0]  del;
  logic [ROOT_W-1:0] root_next;

  // Radicand: loaded on the load cycle, held for the rest of the run.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_reg <= '0;
    end else if (ctrl.en_a && !ctrl.ld_add) begin
      a_reg <= din;
    end
  end

  // sq accumulates the odd step; del is always narrower, so zero-extend it.
  sqrt_ld_add_reg #(
    .W    (SQ_W),
    .INIT (SQ_INIT)
  ) u_sq (
    .clk     (clk),
    .clr     (clr),
    .en      (ctrl.en_sq),
    .ld_add  (ctrl.ld_add),
    .add_val (SQ_W'(del)),
    .q       (sq)
  );

  sqrt_ld_add_reg #(
    .W    (DEL_W),
    .INIT (DEL_INIT)
  ) u_del (
    .clk     (clk),
    .clr     (clr),
    .en      (ctrl.en_del),
    .ld_add  (ctrl.ld_add),
    .add_val (DEL_W'(DEL_STEP)),
    .q       (del)
  );

  // Settles half a cycle before the controller samples it on negedge.
  assign ctrl.greater = (sq > SQ_W'(a_reg));

  // del = 2r+3 once sq has overshot, so r = del/2 - 1.
  assign root_next = ROOT_W'((del >> 1) - DEL_W'(1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      root       <= '0;
      root_valid <= 1'b0;
    end else begin
      root_valid <= ctrl.en_out;
      if (ctrl.en_out) begin
        root <= root_next;
      end
    end
  end

`ifdef SQRT_DATAPATH_ITER_CNT_EN
  // Counts add steps of the current run; the done edge (en_out) freezes it
  // even though sq/del re-initialise on that same edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      iter_cnt <= '0;
    end else if (ctrl.en_sq && !ctrl.en_out) begin
      if (!ctrl.ld_add) begin
        iter_cnt <= '0;
      end else if (iter_cnt != '1) begin
        iter_cnt <= iter_cnt + (ROOT_W+1)'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sqrt_datapath.sv
// Self-checking bench for sqrt_datapath: the bench plays the controller FSM
// and a scoreboard queue matches each root_valid pulse with its expected root.
module tb_sqrt_datapath;
  import sqrt_pkg::*;

  localparam int WIDTH  = 8;
  localparam int ROOT_W = WIDTH / 2;

  logic              clk = 1'b0;
  logic              clr;
  logic [WIDTH-1:0]  din;
  logic [ROOT_W-1:0] root;
  logic              root_valid;
`ifdef SQRT_DATAPATH_ITER_CNT_EN
  logic [ROOT_W:0]   iter_cnt;
`endif

  sqrt_datapath_if ctrl ();

  sqrt_datapath #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .clr        (clr),
    .din        (din),
    .ctrl       (ctrl),
    .root       (root),
    .root_valid (root_valid)
`ifdef SQRT_DATAPATH_ITER_CNT_EN
    ,
    .iter_cnt   (iter_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int valid_seen = 0;
  int popped;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic drive(input logic a, input logic s, input logic d, input logic o, input logic l);
    ctrl.en_a   = a;
    ctrl.en_sq  = s;
    ctrl.en_del = d;
    ctrl.en_out = o;
    ctrl.ld_add = l;
  endtask

  // Scoreboard: every root_valid pulse must match the oldest outstanding root.
  always @(negedge clk) begin
    if (root_valid) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        popped = exp_q.pop_front();
        check("root", root, popped);
      end
    end
  end

  // One full controller run; extra_out repeats en_out once after done.
  task automatic run(input int v, input bit extra_out);
    int m_sq, m_del, adds, exp_r, base;
    bit reached;
    exp_r   = isqrt(v);
    reached = 1'b0;
    adds    = 0;
    @(negedge clk);
    din = v;
    drive(1, 1, 1, 0, 0);
    @(posedge clk);
    m_sq  = SQ_INIT;
    m_del = DEL_INIT;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("sq", dut.sq, m_sq);
      check("del", dut.del, m_del);
      check("greater", ctrl.greater, m_sq > v);
      if (ctrl.greater) begin
        reached = 1'b1;
        break;
      end
      drive(0, 1, 1, 0, 1);
      @(posedge clk);
      m_sq  += m_del;
      m_del += DEL_STEP;
      adds++;
    end
    check("run_timeout", reached, 1);
    check("add_steps", adds, exp_r);
    base = valid_seen;
    exp_q.push_back(exp_r);
    drive(0, 1, 1, 1, 0);
    @(negedge clk);
    check("sq_reinit", dut.sq, SQ_INIT);
    check("del_reinit", dut.del, DEL_INIT);
    if (extra_out) begin
      // del is back at 3, so the repeated latch yields 3/2 - 1 = 0.
      exp_q.push_back(0);
      drive(0, 0, 0, 1, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("valid_pulses", valid_seen - base, extra_out ? 2 : 1);
    check("valid_low", root_valid, 0);
    check("root_hold", root, extra_out ? 0 : exp_r);
`ifdef SQRT_DATAPATH_ITER_CNT_EN
    repeat (2) @(negedge clk);
    check("iter_cnt", iter_cnt, exp_r);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    clr = 1'b1;
    din = '0;
    drive(0, 0, 0, 0, 0);
    #12;
    check("rst_sq", dut.sq, 0);
    check("rst_del", dut.del, 0);
    check("rst_root", root, 0);
    check("rst_valid", root_valid, 0);
    check("rst_greater", ctrl.greater, 0);
    @(negedge clk);
    clr = 1'b0;

    run(0, 1'b0);
    run(9, 1'b0);
    run(255, 1'b0);
    run(10, 1'b1);
    run(15, 1'b0);

    // Abort a din=200 run after two add steps.
    @(negedge clk);
    din = 200;
    drive(1, 1, 1, 0, 0);
    @(negedge clk);
    drive(0, 1, 1, 0, 1);
    repeat (2) @(negedge clk);
    base = valid_seen;
    clr  = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;
    check("abort_sq", dut.sq, 0);
    check("abort_del", dut.del, 0);
    check("abort_a", dut.a_reg, 0);
    check("abort_root", root, 0);
    check("abort_valid", root_valid, 0);
    check("abort_greater", ctrl.greater, 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_valid", valid_seen - base, 0);
    check("abort_root_idle", root, 0);

    run(200, 1'b0);
    run(100, 1'b0);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
